aes_block_loader: RTL and testbench

//  Upstream feeder for the AES encryption core. Accepts 32-bit words over a valid/ready stream and

---
 rtl/aes_block_loader.sv | 149 ++++++++++++++
 tb/tb_aes_block_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_loader.sv
// aes_block_loader: gathers four 32-bit stream words into one 128-bit key or
// plaintext block. It presents the block on the AES core's shared KeyPlaintext
// bus with a one-cycle LoadKey or LoadData strobe. No new block is issued while
// a key expansion or an encryption is still in flight.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   word stream handshake (in_word, in_is_key)
//   abort               drops a partially collected block while collecting
//   block_out           block presented to the core, updated only at issue
//   load_key/load_data  one-cycle strobes to the core
//   ct_valid            core completion of an encryption
//   busy                a block is being issued or the core is still working
//   timeout_err         sticky; set when ct_valid never arrives
//   word_cnt            number of words collected for the current block
module aes_block_loader #(
    parameter int unsigned KEY_GAP = 12,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         in_is_key,
    input  logic         abort,
    output logic [127:0] block_out,
    output logic         load_key,
    output logic         load_data,
    input  logic         ct_valid,
    output logic         busy,
    output logic         timeout_err,
    output logic [1:0]   word_cnt
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ASM_W   = 3 * WORD_W;
    localparam int unsigned CNT_MAX = (KEY_GAP > TIMEOUT) ? KEY_GAP : TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        ISSUE    = 2'd1,
        KEY_WAIT = 2'd2,
        CT_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ASM_W-1:0]   asm_q;
    logic               key_flag_q;
    logic               rdy_en_q;
    logic               xfer_c;
    logic               last_word_c;
    logic               timeout_hit_c;

    // rdy_en_q keeps the stream stalled while reset is asserted.
    assign in_ready      = rdy_en_q && (state_q == COLLECT) && !abort;
    assign xfer_c        = in_valid && in_ready;
    assign last_word_c   = xfer_c && (word_cnt == 2'd3);
    assign timeout_hit_c = (state_q == CT_WAIT) && !ct_valid
                           && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state and pacing counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (last_word_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (key_flag_q) begin
                    state_d = KEY_WAIT;
                    cnt_d   = CNT_W'(KEY_GAP - 1);
                end else begin
                    state_d = CT_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CT_WAIT: begin
                // ct_valid takes priority over a coincident timeout.
                if (ct_valid || timeout_hit_c) begin
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q    <= 1'b0;
            asm_q       <= '0;
            key_flag_q  <= 1'b0;
            word_cnt    <= '0;
            block_out   <= '0;
            load_key    <= 1'b0;
            load_data   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rdy_en_q  <= 1'b1;
            busy      <= (state_d != COLLECT);
            // The strobe lands in the ISSUE cycle, together with the new block.
            load_key  <= last_word_c && key_flag_q;
            load_data <= last_word_c && !key_flag_q;
            if (state_q == COLLECT && abort) begin
                word_cnt <= '0;
            end else if (xfer_c) begin
                word_cnt <= word_cnt + 2'd1;
                asm_q    <= {asm_q[ASM_W-WORD_W-1:0], in_word};
                if (word_cnt == 2'd0) begin
                    key_flag_q <= in_is_key;
                end
            end
            if (last_word_c) begin
                block_out <= {asm_q, in_word};
            end
            if (timeout_hit_c) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader with default parameters (KEY_GAP=12, TIMEOUT=64).
module tb_aes_block_loader;

    localparam int unsigned KEY_GAP = 12;
    localparam int unsigned TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         in_is_key;
    logic         abort;
    logic [127:0] block_out;
    logic         load_key;
    logic         load_data;
    logic         ct_valid;
    logic         busy;
    logic         timeout_err;
    logic [1:0]   word_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    aes_block_loader #(.KEY_GAP(KEY_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_is_key(in_is_key), .abort(abort),
        .block_out(block_out), .load_key(load_key), .load_data(load_data),
        .ct_valid(ct_valid), .busy(busy), .timeout_err(timeout_err),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic k);
        in_valid  = 1'b1;
        in_word   = w;
        in_is_key = k;
        tick();
        in_valid  = 1'b0;
        in_is_key = 1'b0;
    endtask

    // kf[3] is the type flag of word 0, kf[0] of word 3.
    task automatic send_block(input logic [127:0] b, input logic [3:0] kf);
        for (int i = 0; i < 4; i++) begin
            send(b[127-32*i -: 32], kf[3-i]);
        end
    endtask

    localparam logic [127:0] KEY  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PT   = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] BLK4 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] BLK6 = 128'hA0A0A0A0B1B1B1B1C2C2C2C2D3D3D3D3;

    initial begin
        logic seen;
        rst = 1'b0; in_valid = 1'b0; in_word = '0; in_is_key = 1'b0;
        abort = 1'b0; ct_valid = 1'b0;
        #3;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_block_out", block_out, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_word_cnt", 128'(word_cnt), 128'(0));
        rst = 1'b1;
        tick();
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        // 1: key block, LoadKey strobe, stall for KEY_GAP cycles
        send_block(KEY, 4'b1000);
        chk("t1_block_out", block_out, KEY);
        chk("t1_load_key", 128'(load_key), 128'(1));
        chk("t1_load_data", 128'(load_data), 128'(0));
        chk("t1_busy", 128'(busy), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < int'(KEY_GAP); i++) begin
            tick();
            if (in_ready || load_key) seen = 1'b1;
        end
        chk("t1_gap_stall", 128'(seen), 128'(0));
        tick();
        chk("t1_ready_back", 128'(in_ready), 128'(1));
        chk("t1_block_hold", block_out, KEY);

        // 2: data block, ct_valid after 20 cycles
        send_block(PT, 4'b0000);
        chk("t2_block_out", block_out, PT);
        chk("t2_load_data", 128'(load_data), 128'(1));
        chk("t2_load_key", 128'(load_key), 128'(0));
        repeat (20) tick();
        chk("t2_busy", 128'(busy), 128'(1));
        chk("t2_stall", 128'(in_ready), 128'(0));
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        chk("t2_ready", 128'(in_ready), 128'(1));
        chk("t2_idle", 128'(busy), 128'(0));
        chk("t2_no_err", 128'(timeout_err), 128'(0));

        // 3: type flag sampled on word 0 only
        send_block(BLK4, 4'b1000);
        chk("t3_load_key", 128'(load_key), 128'(1));
        chk("t3_load_data", 128'(load_data), 128'(0));
        repeat (KEY_GAP + 1) tick();
        chk("t3_ready", 128'(in_ready), 128'(1));

        // 4: abort after two words blocks the coincident word, then a fresh block
        send(32'hDEADBEEF, 1'b1);
        send(32'hCAFEF00D, 1'b1);
        chk("t4_two_words", 128'(word_cnt), 128'(2));
        in_valid = 1'b1; in_word = 32'h0BADF00D; abort = 1'b1;
        #1;
        chk("t4_abort_ready", 128'(in_ready), 128'(0));
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("t4_cnt_cleared", 128'(word_cnt), 128'(0));
        send_block(BLK4, 4'b0000);
        chk("t4_block_out", block_out, BLK4);
        chk("t4_load_data", 128'(load_data), 128'(1));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_ignored", 128'(busy), 128'(1));
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        chk("t4_ready", 128'(in_ready), 128'(1));

        // ct_valid coincident with the timeout cycle: no error
        send_block(PT, 4'b0000);
        repeat (TIMEOUT) tick();
        chk("tc_busy", 128'(busy), 128'(1));
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        chk("tc_no_err", 128'(timeout_err), 128'(0));
        chk("tc_ready", 128'(in_ready), 128'(1));

        // 5: timeout with ct_valid never asserted
        send_block(PT, 4'b0000);
        chk("t5_strobe", 128'(load_data), 128'(1));
        repeat (TIMEOUT) tick();
        chk("t5_err_not_yet", 128'(timeout_err), 128'(0));
        chk("t5_busy", 128'(busy), 128'(1));
        tick();
        chk("t5_err", 128'(timeout_err), 128'(1));
        chk("t5_idle", 128'(busy), 128'(0));
        chk("t5_ready", 128'(in_ready), 128'(1));
        ct_valid = 1'b1;
        tick();
        ct_valid = 1'b0;
        chk("t5_err_sticky", 128'(timeout_err), 128'(1));

        // 6a: reset during CT_WAIT
        send_block(BLK6, 4'b0000);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("t6_block_out", block_out, '0);
        chk("t6_busy", 128'(busy), 128'(0));
        chk("t6_err", 128'(timeout_err), 128'(0));
        chk("t6_ready", 128'(in_ready), 128'(0));
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 8; i++) begin
            tick();
            if (load_key || load_data || busy || timeout_err) seen = 1'b1;
        end
        chk("t6_quiet", 128'(seen), 128'(0));

        // 6b: reset during the third word
        send(32'h01020304, 1'b0);
        send(32'h05060708, 1'b0);
        in_valid = 1'b1; in_word = 32'h090A0B0C;
        #2;
        rst = 1'b0;
        #1;
        chk("t6b_word_cnt", 128'(word_cnt), 128'(0));
        chk("t6b_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (load_key || load_data || busy) seen = 1'b1;
        end
        chk("t6b_quiet", 128'(seen), 128'(0));
        send(BLK6[127:96], 1'b0);
        chk("t6b_fresh_cnt", 128'(word_cnt), 128'(1));
        send(BLK6[95:64], 1'b0);
        send(BLK6[63:32], 1'b0);
        send(BLK6[31:0], 1'b0);
        chk("t6b_block_out", block_out, BLK6);
        chk("t6b_load_data", 128'(load_data), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
